// File: rtl/ula_agu_pipe.sv
// rtl/ula_agu_pipe.sv - two-stage pipelined register-op / address-generation adder
// Optional {N,Z,C,V} flag outputs are built only when ULA_FLAGS_EN is defined.
module ula_agu_pipe #(
  parameter int WIDTH    = 64,
  parameter int OFFSET_W = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    dinA,
  input  logic [WIDTH-1:0]    dinB,
  input  logic [OFFSET_W-1:0] OFFSET,
  input  logic                OP_MEM,
  input  logic                ADD_SUB,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    dout
`ifdef ULA_FLAGS_EN
  ,
  output logic [3:0]          flags
`endif
);

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_op0;
  logic [WIDTH-1:0] r_op1;
  logic             r_sub;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_dout;

  logic             w_s2_adv;
  logic             w_in_ready;
  logic [WIDTH-1:0] w_sext;
  logic [WIDTH-1:0] w_op1_eff;
  logic [WIDTH-1:0] w_sum;
  logic             w_carry;

  assign w_sext     = {{(WIDTH-OFFSET_W){OFFSET[OFFSET_W-1]}}, OFFSET};
  assign w_s2_adv   = !r_out_valid || out_ready;
  assign w_in_ready = !r_s1_valid || w_s2_adv;

  // Subtract folds into the same adder: op0 + ~op1 + 1, so carry-out doubles as "no borrow".
  assign w_op1_eff          = r_sub ? ~r_op1 : r_op1;
  assign {w_carry, w_sum}   = {1'b0, r_op0} + {1'b0, w_op1_eff} + {{WIDTH{1'b0}}, r_sub};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_op0      <= '0;
      r_op1      <= '0;
      r_sub      <= 1'b0;
    end else if (w_in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_op0 <= OP_MEM ? dinB : dinA;
        r_op1 <= OP_MEM ? w_sext : dinB;
        r_sub <= ADD_SUB;
      end
    end
  end

  // A bubble from s1 drops out_valid but leaves dout untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_dout      <= '0;
    end else if (w_s2_adv) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_dout <= w_sum;
      end
    end
  end

`ifdef ULA_FLAGS_EN
  logic [3:0] r_flags;
  logic [3:0] w_flags;

  assign w_flags = {w_sum[WIDTH-1],
                    (w_sum == '0),
                    w_carry,
                    (r_op0[WIDTH-1] == w_op1_eff[WIDTH-1]) && (w_sum[WIDTH-1] != r_op0[WIDTH-1])};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags <= 4'b0;
    end else if (w_s2_adv && r_s1_valid) begin
      r_flags <= w_flags;
    end
  end

  assign flags = r_flags;
`endif

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign dout      = r_dout;

endmodule

// File: tb/tb_ula_agu_pipe.sv
// tb/tb_ula_agu_pipe.sv - scoreboard bench for ula_agu_pipe
// Flag checks are compiled in only when ULA_FLAGS_EN is defined.
module tb_ula_agu_pipe;
  localparam int W = 64;

  logic         clk       = 1'b0;
  logic         rst_n     = 1'b1;
  logic         in_valid  = 1'b0;
  logic         out_ready = 1'b0;
  logic         OP_MEM    = 1'b0;
  logic         ADD_SUB   = 1'b0;
  logic [W-1:0] dinA      = '0;
  logic [W-1:0] dinB      = '0;
  logic [4:0]   OFFSET    = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] dout;
`ifdef ULA_FLAGS_EN
  logic [3:0]   flags;
`endif

  typedef struct packed {
    logic [W-1:0] d;
    logic [3:0]   f;
  } exp_t;

  exp_t         sb_q[$];
  int           n_vec = 0;
  int           n_err = 0;
  logic         hold_pend = 1'b0;
  logic [W-1:0] hold_val  = '0;

  always #5 clk = ~clk;

  ula_agu_pipe #(.WIDTH(W), .OFFSET_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dinA      (dinA),
    .dinB      (dinB),
    .OFFSET    (OFFSET),
    .OP_MEM    (OP_MEM),
    .ADD_SUB   (ADD_SUB),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout)
`ifdef ULA_FLAGS_EN
    ,
    .flags     (flags)
`endif
  );

  task automatic check_val(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic mem, input logic sub, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic [4:0] off);
    logic signed [4:0] so;
    logic [W-1:0] x, y, r;
    logic c, v;
    so = off;
    x = mem ? b : a;
    y = mem ? W'(so) : b;
    r = sub ? x - y : x + y;
    c = sub ? (x >= y) : (r < x);
    v = sub ? ((x[W-1] != y[W-1]) && (r[W-1] != x[W-1]))
            : ((x[W-1] == y[W-1]) && (r[W-1] != x[W-1]));
    model.d = r;
    model.f = {r[W-1], (r == '0), c, v};
  endfunction

  task automatic step(input logic iv, input logic ordy, input logic mem, input logic sub,
                      input logic [W-1:0] a, input logic [W-1:0] b, input logic [4:0] off,
                      output logic acc);
    exp_t e;
    @(negedge clk);
    if (hold_pend) begin
      check_val("hold_valid", 64'(out_valid), 64'd1);
      check_val("hold_dout", dout, hold_val);
    end
    in_valid = iv; out_ready = ordy; OP_MEM = mem; ADD_SUB = sub;
    dinA = a; dinB = b; OFFSET = off;
    #1;
    if (out_valid && out_ready) begin
      check_val("sb_occupied", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check_val("dout", dout, e.d);
`ifdef ULA_FLAGS_EN
        check_val("flags", 64'(flags), 64'(e.f));
`endif
      end
    end
    acc = in_valid && in_ready;
    if (acc) sb_q.push_back(model(mem, sub, a, b, off));
    hold_pend = out_valid && !out_ready;
    hold_val  = dout;
  endtask

  task automatic idle(input logic ordy);
    logic acc;
    step(1'b0, ordy, 1'b0, 1'b0, '0, '0, '0, acc);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || out_valid) && n < 64) begin
      idle(1'b1);
      n++;
    end
    check_val("drain_left", 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    logic acc;
    int   accepted;
    int   cyc;

    // Reset state, then a single register add and its latency
    #2 rst_n = 1'b0;
    #1;
    check_val("rst_out_valid", 64'(out_valid), 64'd0);
    check_val("rst_dout", dout, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_val("rst_in_ready", 64'(in_ready), 64'd1);

    step(1'b1, 1'b1, 1'b0, 1'b0, 64'd5, 64'd7, 5'd0, acc);
    check_val("t1_accept", 64'(acc), 64'd1);
    idle(1'b1);
    check_val("t1_lat1_ov", 64'(out_valid), 64'd0);
    idle(1'b1);
    check_val("t1_lat2_ov", 64'(out_valid), 64'd1);
    check_val("t1_dout", dout, 64'd12);
    drain();

    // Address mode with negative offset, add then subtract
    step(1'b1, 1'b1, 1'b1, 1'b0, 64'd0, 64'h1000, 5'b11100, acc);
    step(1'b1, 1'b1, 1'b1, 1'b1, 64'd0, 64'h1000, 5'b11100, acc);
    idle(1'b1);
    check_val("t2_add_dout", dout, 64'h0FFC);
    idle(1'b1);
    check_val("t2_sub_dout", dout, 64'h1004);
    drain();

    // Backpressure: two beats fill the pipe, then release and stream
    step(1'b1, 1'b0, 1'b0, 1'b0, 64'd100, 64'd1, 5'd0, acc);
    step(1'b1, 1'b0, 1'b0, 1'b0, 64'd200, 64'd2, 5'd0, acc);
    step(1'b1, 1'b0, 1'b0, 1'b0, 64'd300, 64'd3, 5'd0, acc);
    check_val("t3_in_ready_low", 64'(in_ready), 64'd0);
    check_val("t3_accepted", 64'(sb_q.size()), 64'd2);
    check_val("t3_dout_beat0", dout, 64'd101);
    step(1'b1, 1'b0, 1'b0, 1'b0, 64'd300, 64'd3, 5'd0, acc);
    step(1'b1, 1'b1, 1'b0, 1'b0, 64'd300, 64'd3, 5'd0, acc);
    check_val("t3_ov_a", 64'(out_valid), 64'd1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 64'd400, 64'd4, 5'd0, acc);
    check_val("t3_ov_b", 64'(out_valid), 64'd1);
    idle(1'b1);
    check_val("t3_ov_c", 64'(out_valid), 64'd1);
    check_val("t3_dout_c", dout, 64'd303);
    idle(1'b1);
    check_val("t3_ov_d", 64'(out_valid), 64'd1);
    check_val("t3_dout_d", dout, 64'd404);
    drain();

    // Wraparound and flag corners
    step(1'b1, 1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd0, acc);
    step(1'b1, 1'b1, 1'b0, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 5'd0, acc);
    step(1'b1, 1'b1, 1'b0, 1'b1, 64'd3, 64'd5, 5'd0, acc);
    check_val("t4_wrap_dout", dout, 64'd0);
`ifdef ULA_FLAGS_EN
    check_val("t4_wrap_flags", 64'(flags), 64'(4'b0110));
`endif
    idle(1'b1);
    check_val("t4_ovf_dout", dout, 64'h8000_0000_0000_0000);
`ifdef ULA_FLAGS_EN
    check_val("t4_ovf_flags", 64'(flags), 64'(4'b1001));
`endif
    idle(1'b1);
    check_val("t4_neg_dout", dout, 64'hFFFF_FFFF_FFFF_FFFE);
`ifdef ULA_FLAGS_EN
    check_val("t4_neg_flags", 64'(flags), 64'(4'b1000));
`endif
    drain();

    // Asynchronous reset with two beats in flight
    step(1'b1, 1'b0, 1'b0, 1'b0, 64'd11, 64'd22, 5'd0, acc);
    step(1'b1, 1'b0, 1'b0, 1'b0, 64'd33, 64'd44, 5'd0, acc);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_val("t5_rst_ov", 64'(out_valid), 64'd0);
    check_val("t5_rst_dout", dout, 64'd0);
    sb_q.delete();
    hold_pend = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idle(1'b1);
      check_val("t5_no_stale", 64'(out_valid), 64'd0);
    end

    // Random stress
    accepted = 0;
    cyc = 0;
    while (accepted < 10000 && cyc < 40000) begin
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
           1'($urandom()), 1'($urandom()),
           {$urandom(), $urandom()}, {$urandom(), $urandom()}, 5'($urandom()), acc);
      if (acc) accepted++;
      cyc++;
    end
    check_val("t6_accepted", 64'(accepted), 64'd10000);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
